// File: rtl/xnor_pkg.sv
// Shared constants for the XNOR window generator and PE.
// Window bit r*KERNEL+c: r=0 is the oldest (top) row, c=0 the oldest (left) column.
package xnor_pkg;
  localparam int KERNEL   = 5;
  localparam int WIN_BITS = KERNEL * KERNEL;
  localparam int POP_BITS = 6;
  localparam int NUM_LB   = KERNEL - 1;

  function automatic int win_idx(input int r, input int c);
    return r * KERNEL + c;
  endfunction
endpackage

// File: rtl/xnor_line_buffer.sv
// One image row of 1-bit delay; dout_o is the pixel shifted in DEPTH enables ago.
// Zero latency read of the oldest entry, advances only when shift_en_i is high.
module xnor_line_buffer #(
  parameter int DEPTH = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic shift_en_i,
  input  logic din_i,
  output logic dout_o
);
  logic [DEPTH-1:0] dl_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dl_q <= '0;
    end else if (shift_en_i) begin
      dl_q <= {dl_q[DEPTH-2:0], din_i};
    end
  end

  assign dout_o = dl_q[DEPTH-1];
endmodule

// File: rtl/xnor_window_gen.sv
// Streams 1-bit pixels in, emits every full 5x5 valid-conv window one cycle after its last pixel.
// One-deep output register; in_ready drops only while a window is held against out_ready=0.
module xnor_window_gen
  import xnor_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_pix,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIN_BITS-1:0] out_win,
  output logic                out_last
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL - 1);

  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [WIN_BITS-1:0] win_q, win_d;
  logic                out_valid_q, out_valid_d;
  logic [WIN_BITS-1:0] out_win_q, out_win_d;
  logic                out_last_q, out_last_d;
  logic                accept, emit;
  // tap[k] is the pixel k rows above the incoming one, same column
  logic [NUM_LB:0]     tap;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign emit     = accept && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
  assign tap[0]   = in_pix;

  for (genvar g = 0; g < NUM_LB; g++) begin : g_lb
    xnor_line_buffer #(.DEPTH(IMG_W)) u_lb (
      .clk_i     (clk),
      .rst_ni    (reset),
      .shift_en_i(accept),
      .din_i     (tap[g]),
      .dout_o    (tap[g+1])
    );
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL - 1; c++) begin
          win_d[win_idx(r, c)] = win_q[win_idx(r, c + 1)];
        end
        win_d[win_idx(r, KERNEL - 1)] = tap[KERNEL - 1 - r];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_win_d   = out_win_q;
    out_last_d  = out_last_q;
    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // win_d already holds the new column, so it is the window ending at (row_q, col_q)
    if (emit) begin
      out_valid_d = 1'b1;
      out_win_d   = win_d;
      out_last_d  = (row_q == ROW_MAX) && (col_q == COL_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_win_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_win_q   <= out_win_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_win   = out_win_q;
  assign out_last  = out_last_q;
endmodule

// File: tb/tb_xnor_window_gen.sv
// Bench for xnor_window_gen on an 8x8 image: directed frames checked against an image-based window model.
module tb_xnor_window_gen;
  localparam int W = 8;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_pix = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [24:0] out_win;
  logic        out_last;

  int checks = 0;
  int failures = 0;
  int rx_cnt = 0;
  int exp_total = 0;
  bit rnd_rdy = 1'b0;
  bit gaps = 1'b0;
  bit lat_chk = 1'b0;
  logic [25:0] exp_q[$];

  xnor_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pix   (in_pix),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_win  (out_win),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected {last, window} for the window whose bottom-right pixel is (r,c).
  function automatic logic [25:0] model_win(input logic [63:0] img, input int r, input int c);
    logic [25:0] e;
    e = '0;
    for (int rr = 0; rr < 5; rr++)
      for (int cc = 0; cc < 5; cc++)
        e[rr*5+cc] = img[(r-4+rr)*W + (c-4+cc)];
    e[25] = (r == H-1) && (c == W-1);
    return e;
  endfunction

  task automatic push_frame(input logic [63:0] img);
    for (int r = 4; r < H; r++)
      for (int c = 4; c < W; c++)
        exp_q.push_back(model_win(img, r, c));
    exp_total += (W-4)*(H-4);
  endtask

  task automatic send_pixel(input logic p);
    int waited;
    bit done;
    waited = 0;
    done = 1'b0;
    if (gaps && ($urandom_range(1, 0) == 1)) begin
      repeat ($urandom_range(3, 1)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_pix = p;
    while (!done && waited < 200) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic send_frame(input logic [63:0] img, input int npix);
    for (int i = 0; i < npix; i++) begin
      send_pixel(img[i]);
      if (lat_chk) check("latency_valid", 32'(out_valid), 32'(((i / W) >= 4) && ((i % W) >= 4)));
    end
  endtask

  task automatic drain(input int base, input int want);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("window_count", 32'(rx_cnt - base), 32'(want));
  endtask

  // Compare process: every window handed over must match the model in order.
  logic        prev_hold = 1'b0;
  logic [24:0] prev_win = '0;
  logic        prev_last = 1'b0;
  initial begin
    logic [25:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_hold = 1'b0;
      end else begin
        check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
        if (prev_hold) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_win", 32'(out_win), 32'(prev_win));
          check("hold_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid && out_ready) begin
          rx_cnt++;
          check("window_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("win", 32'(out_win), 32'(e[24:0]));
            check("last", 32'(out_last), 32'(e[25]));
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_win  = out_win;
        prev_last = out_last;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(1, 0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ones, chk, single, zero, pat, rnd_a, rnd_b;
    int base;
    ones = '1;
    zero = '0;
    single = 64'd1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        chk[r*W+c] = 1'((r + c) & 1);
        pat[r*W+c] = (((r*3 + c*5 + r*c) % 3) == 0);
      end
    rnd_a = {$urandom, $urandom};
    rnd_b = {$urandom, $urandom};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_win", 32'(out_win), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;

    // All ones, full-rate, latency tracked per pixel
    push_frame(ones);
    check("model_ones_first", 32'(exp_q[0]), 32'h1FFFFFF);
    check("model_ones_last", 32'(exp_q[15]), 32'h3FFFFFF);
    lat_chk = 1'b1;
    base = rx_cnt;
    send_frame(ones, 64);
    drain(base, 16);

    // Checkerboard
    push_frame(chk);
    check("model_chk_44", 32'(exp_q[0]), 32'h0AAAAAA);
    check("model_chk_45", 32'(exp_q[1]), 32'h1555555);
    check("model_chk_54", 32'(exp_q[4]), 32'h1555555);
    base = rx_cnt;
    send_frame(chk, 64);
    drain(base, 16);

    // Single 1 at origin, then an all-zero frame back to back
    push_frame(single);
    push_frame(zero);
    check("model_single_first", 32'(exp_q[0]), 32'h0000001);
    check("model_single_second", 32'(exp_q[1]), 32'h0);
    base = rx_cnt;
    send_frame(single, 64);
    send_frame(zero, 64);
    drain(base, 32);

    // Backpressure for 10 cycles while the window for (4,4) is held
    lat_chk = 1'b0;
    push_frame(pat);
    base = rx_cnt;
    fork
      send_frame(pat, 64);
      begin
        repeat (37) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain(base, 16);

    // Abort a frame with a window held, then a clean all-ones frame
    send_frame(ones, 36);
    out_ready = 1'b0;
    send_pixel(1'b1);
    check("abort_held_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_win", 32'(out_win), 32'd0);
    check("abort_out_last", 32'(out_last), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    push_frame(ones);
    lat_chk = 1'b1;
    base = rx_cnt;
    send_frame(ones, 64);
    drain(base, 16);

    // Random frames with input gaps and random out_ready
    lat_chk = 1'b0;
    gaps = 1'b1;
    rnd_rdy = 1'b1;
    push_frame(rnd_a);
    push_frame(rnd_b);
    base = rx_cnt;
    send_frame(rnd_a, 64);
    send_frame(rnd_b, 64);
    drain(base, 32);
    rnd_rdy = 1'b0;
    gaps = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    check("total_windows", 32'(rx_cnt), 32'(exp_total));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
